// File: rtl/keccak_arbiter.sv
// keccak_arbiter: round-robin sharing of one keccak core among NREQ users.
// Latches the winner's config, streams its input words, pulses done on output.
module keccak_arbiter #(
  parameter int NREQ     = 2,
  parameter int BW_DATA  = 64,
  parameter int BW_IBLEN = 11,
  parameter int BW_OBLEN = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [NREQ-1:0]          i_req,
  input  logic [2*NREQ-1:0]        i_req_mode,
  input  logic [BW_DATA*NREQ-1:0]  i_req_ibytes,
  input  logic [NREQ-1:0]          i_req_ibytes_valid,
  input  logic [BW_IBLEN*NREQ-1:0] i_req_ibytes_len,
  input  logic [BW_OBLEN*NREQ-1:0] i_req_obytes_len,
  output logic [NREQ-1:0]          o_req_gnt,
  output logic [NREQ-1:0]          o_req_ibytes_ready,
  output logic [NREQ-1:0]          o_req_done,
  output logic [1:0]               o_kc_mode,
  output logic [BW_DATA-1:0]       o_kc_ibytes,
  output logic                     o_kc_ibytes_valid,
  output logic [BW_IBLEN-1:0]      o_kc_ibytes_len,
  output logic [BW_OBLEN-1:0]      o_kc_obytes_len,
  input  logic                     i_kc_ibytes_ready,
  input  logic                     i_kc_obytes_valid
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int CW = BW_IBLEN - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gidx;
  logic [IW-1:0]       pick;
  logic                found;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [1:0]          mode;
  logic [BW_IBLEN-1:0] ilen;
  logic [BW_OBLEN-1:0] olen;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       nwords;
  logic [BW_IBLEN:0]   len_rnd;
  logic                feed;
  logic                fire;
  logic                last;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && i_req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  // Zero-length input still needs one (padding-only) beat.
  assign len_rnd = {1'b0, ilen} + (BW_IBLEN+1)'(7);
  assign nwords  = (ilen == '0) ? CW'(1) : len_rnd[BW_IBLEN:3];

  assign feed = (state == S_FEED);
  assign fire = feed && i_req_ibytes_valid[gidx] && i_kc_ibytes_ready;
  assign last = fire && (cnt == nwords - CW'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (found) state_nx = S_GRANT;
      S_GRANT: state_nx = S_FEED;
      S_FEED:  if (last) state_nx = S_WAIT;
      S_WAIT:  if (i_kc_obytes_valid) state_nx = S_DONE;
      S_DONE:  if (!i_kc_obytes_valid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr  <= '0;
      gidx <= '0;
      gnt  <= '0;
      done <= '0;
      mode <= '0;
      ilen <= '0;
      olen <= '0;
      cnt  <= '0;
    end else begin
      done <= '0;
      if (state == S_IDLE && found) begin
        gnt  <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
        gidx <= pick;
        mode <= i_req_mode[pick*2 +: 2];
        ilen <= i_req_ibytes_len[pick*BW_IBLEN +: BW_IBLEN];
        olen <= i_req_obytes_len[pick*BW_OBLEN +: BW_OBLEN];
      end
      if (fire) cnt <= cnt + CW'(1);
      if (state == S_WAIT && i_kc_obytes_valid) done <= gnt;
      if (state == S_DONE && !i_kc_obytes_valid) begin
        gnt <= '0;
        cnt <= '0;
        ptr <= (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
      end
    end
  end

  assign o_req_gnt          = gnt;
  assign o_req_done         = done;
  assign o_req_ibytes_ready = feed ? (gnt & {NREQ{i_kc_ibytes_ready}}) : '0;
  assign o_kc_ibytes        = feed ? i_req_ibytes[gidx*BW_DATA +: BW_DATA] : '0;
  assign o_kc_ibytes_valid  = feed && i_req_ibytes_valid[gidx];
  assign o_kc_mode          = mode;
  assign o_kc_ibytes_len    = ilen;
  assign o_kc_obytes_len    = olen;

endmodule

// File: tb/tb_keccak_arbiter.sv
// tb_keccak_arbiter: directed tests for the two-requester keccak arbiter.
// Each scenario task drives transactions and compares against hand values.
module tb_keccak_arbiter;

  logic         clk;
  logic         rstn;
  logic [1:0]   i_req;
  logic [3:0]   i_req_mode;
  logic [127:0] i_req_ibytes;
  logic [1:0]   i_req_ibytes_valid;
  logic [21:0]  i_req_ibytes_len;
  logic [19:0]  i_req_obytes_len;
  logic [1:0]   o_req_gnt;
  logic [1:0]   o_req_ibytes_ready;
  logic [1:0]   o_req_done;
  logic [1:0]   o_kc_mode;
  logic [63:0]  o_kc_ibytes;
  logic         o_kc_ibytes_valid;
  logic [10:0]  o_kc_ibytes_len;
  logic [9:0]   o_kc_obytes_len;
  logic         i_kc_ibytes_ready;
  logic         i_kc_obytes_valid;

  int checks;
  int errors;

  keccak_arbiter dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_req              (i_req),
    .i_req_mode         (i_req_mode),
    .i_req_ibytes       (i_req_ibytes),
    .i_req_ibytes_valid (i_req_ibytes_valid),
    .i_req_ibytes_len   (i_req_ibytes_len),
    .i_req_obytes_len   (i_req_obytes_len),
    .o_req_gnt          (o_req_gnt),
    .o_req_ibytes_ready (o_req_ibytes_ready),
    .o_req_done         (o_req_done),
    .o_kc_mode          (o_kc_mode),
    .o_kc_ibytes        (o_kc_ibytes),
    .o_kc_ibytes_valid  (o_kc_ibytes_valid),
    .o_kc_ibytes_len    (o_kc_ibytes_len),
    .o_kc_obytes_len    (o_kc_obytes_len),
    .i_kc_ibytes_ready  (i_kc_ibytes_ready),
    .i_kc_obytes_valid  (i_kc_obytes_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int r, input int b);
    return {16'hC0DE, 16'(r), 32'(b)};
  endfunction

  // Runs one transaction and reports what was observed.
  task automatic xact(
    input  logic [1:0] reqm,
    input  int         len,
    input  int         olen,
    input  logic [1:0] mode,
    input  bit         tog,
    input  bit         chg,
    input  bit         drop,
    input  bit         hold_wait,
    output logic [1:0] g,
    output int         lat,
    output int         beats,
    output int         bad,
    output int         orr,
    output logic [1:0] done_v,
    output int         pulses,
    output logic [1:0] m_o,
    output int         il_o,
    output int         ol_o,
    output logic [1:0] g_after
  );
    int gi;
    for (int r = 0; r < 2; r++) begin
      i_req_mode[2*r +: 2]        = mode ^ 2'(r);
      i_req_ibytes_len[11*r +: 11] = 11'(len);
      i_req_obytes_len[10*r +: 10] = 10'(olen);
      i_req_ibytes[64*r +: 64]    = 64'hDEAD_BEEF_0BAD_F00D;
    end
    i_req = reqm;
    i_req_ibytes_valid = 2'b11;
    g = '0; lat = 0; beats = 0; bad = 0; orr = 0;
    done_v = '0; pulses = 0; m_o = '0; il_o = 0; ol_o = 0; g_after = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      if (|o_req_gnt) break;
    end
    g = o_req_gnt;
    gi = g[1] ? 1 : 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      i_req_ibytes[64*gi +: 64] = word(gi, beats);
      if (chg && beats >= 1) begin
        i_req_mode[2*gi +: 2]        = (mode ^ 2'(gi)) ^ 2'b11;
        i_req_ibytes_len[11*gi +: 11] = 11'd7;
        i_req_obytes_len[10*gi +: 10] = 10'd5;
      end
      if (drop && beats >= 1) i_req[gi] = 1'b0;
      i_kc_ibytes_ready = tog ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (!o_kc_ibytes_valid) break;
      if ((o_req_ibytes_ready & ~g) != 2'b00) orr++;
      if (i_kc_ibytes_ready) begin
        if (o_kc_ibytes !== word(gi, beats)) bad++;
        beats++;
      end
    end
    i_kc_ibytes_ready = 1'b0;
    if (hold_wait) return;
    i_kc_obytes_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        m_o  = o_kc_mode;
        il_o = int'(o_kc_ibytes_len);
        ol_o = int'(o_kc_obytes_len);
      end
      if (|o_req_done) begin
        pulses++;
        done_v = o_req_done;
      end
    end
    i_kc_obytes_valid = 1'b0;
    @(posedge clk); #1;
    g_after = o_req_gnt;
  endtask

  logic [1:0] g, dv, m, ga;
  int lat, beats, bad, orr, pulses, il, ol;

  task automatic test_reset();
    rstn = 1'b0;
    i_req = '0; i_req_mode = '0; i_req_ibytes = '0;
    i_req_ibytes_valid = '0; i_req_ibytes_len = '0; i_req_obytes_len = '0;
    i_kc_ibytes_ready = 1'b0; i_kc_obytes_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_req_gnt !== 2'b00 || o_req_done !== 2'b00 || o_req_ibytes_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_req gnt=%b done=%b rdy=%b want 0", o_req_gnt, o_req_done, o_req_ibytes_ready);
    end
    checks++;
    if (o_kc_mode !== 2'd0 || o_kc_ibytes !== 64'd0 || o_kc_ibytes_valid !== 1'b0 ||
        o_kc_ibytes_len !== 11'd0 || o_kc_obytes_len !== 10'd0) begin
      errors++;
      $display("FAIL reset_kc mode=%0d data=%h v=%b il=%0d ol=%0d want 0",
               o_kc_mode, o_kc_ibytes, o_kc_ibytes_valid, o_kc_ibytes_len, o_kc_obytes_len);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int t = 0; t < 4; t++) begin
      xact(2'b11, 8, 16, 2'd2, 0, 0, 0, 0, g, lat, beats, bad, orr, dv, pulses, m, il, ol, ga);
      checks++;
      if (g !== exp_g[t]) begin
        errors++;
        $display("FAIL fair_gnt t=%0d got %b want %b", t, g, exp_g[t]);
      end
      checks++;
      if (pulses != 1 || dv !== exp_g[t] || beats != 1) begin
        errors++;
        $display("FAIL fair_done t=%0d pulses=%0d done=%b beats=%0d want 1 %b 1",
                 t, pulses, dv, beats, exp_g[t]);
      end
      checks++;
      if (m !== (2'd2 ^ {1'b0, exp_g[t][1]})) begin
        errors++;
        $display("FAIL fair_mode t=%0d got %0d want %0d", t, m, 2'd2 ^ {1'b0, exp_g[t][1]});
      end
    end
    i_req = '0;
  endtask

  task automatic test_single();
    xact(2'b01, 32, 32, 2'd1, 0, 0, 0, 0, g, lat, beats, bad, orr, dv, pulses, m, il, ol, ga);
    i_req = '0;
    checks++;
    if (g !== 2'b01 || lat != 1) begin
      errors++;
      $display("FAIL single_gnt got %b lat %0d want 01 lat 1", g, lat);
    end
    checks++;
    if (beats != 4 || bad != 0) begin
      errors++;
      $display("FAIL single_beats got %0d bad %0d want 4 bad 0", beats, bad);
    end
    checks++;
    if (pulses != 1 || dv !== 2'b01) begin
      errors++;
      $display("FAIL single_done pulses %0d done %b want 1 01", pulses, dv);
    end
    checks++;
    if (orr != 0) begin
      errors++;
      $display("FAIL single_rdy1 other-ready cycles %0d want 0", orr);
    end
    checks++;
    if (m !== 2'd1 || il != 32 || ol != 32) begin
      errors++;
      $display("FAIL single_cfg mode %0d il %0d ol %0d want 1 32 32", m, il, ol);
    end
    checks++;
    if (ga !== 2'b00) begin
      errors++;
      $display("FAIL single_release gnt %b want 00", ga);
    end
  endtask

  task automatic test_lengths();
    int lens [4];
    int expb [4];
    bit togs [4];
    lens = '{33, 0, 1184, 33};
    expb = '{5, 1, 148, 5};
    togs = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 4; t++) begin
      xact(2'b10, lens[t], 64, 2'd3, togs[t], 0, 0, 0, g, lat, beats, bad, orr, dv, pulses, m, il, ol, ga);
      i_req = '0;
      checks++;
      if (beats != expb[t] || bad != 0) begin
        errors++;
        $display("FAIL len_beats len=%0d tog=%0d got %0d bad %0d want %0d bad 0",
                 lens[t], togs[t], beats, bad, expb[t]);
      end
      checks++;
      if (pulses != 1 || dv !== 2'b10 || il != lens[t]) begin
        errors++;
        $display("FAIL len_done len=%0d pulses %0d done %b il %0d want 1 10 %0d",
                 lens[t], pulses, dv, il, lens[t]);
      end
    end
  endtask

  task automatic test_config_stable();
    xact(2'b01, 40, 100, 2'd2, 1, 1, 0, 0, g, lat, beats, bad, orr, dv, pulses, m, il, ol, ga);
    i_req = '0;
    checks++;
    if (m !== 2'd2 || il != 40 || ol != 100) begin
      errors++;
      $display("FAIL cfg_stable mode %0d il %0d ol %0d want 2 40 100", m, il, ol);
    end
    checks++;
    if (beats != 5) begin
      errors++;
      $display("FAIL cfg_beats got %0d want 5", beats);
    end
  endtask

  task automatic test_drop();
    xact(2'b01, 24, 8, 2'd0, 0, 0, 1, 0, g, lat, beats, bad, orr, dv, pulses, m, il, ol, ga);
    i_req = '0;
    checks++;
    if (beats != 3 || pulses != 1 || dv !== 2'b01) begin
      errors++;
      $display("FAIL drop beats %0d pulses %0d done %b want 3 1 01", beats, pulses, dv);
    end
  endtask

  task automatic test_reset_mid();
    xact(2'b01, 16, 8, 2'd1, 0, 0, 0, 1, g, lat, beats, bad, orr, dv, pulses, m, il, ol, ga);
    checks++;
    if (beats != 2 || g !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre beats %0d gnt %b want 2 01", beats, g);
    end
    i_kc_ibytes_ready = 1'b1;
    rstn = 1'b0;
    #1;
    checks++;
    if (o_req_gnt !== 2'b00 || o_req_ibytes_ready !== 2'b00 || o_kc_mode !== 2'd0 ||
        o_kc_ibytes_len !== 11'd0 || o_kc_obytes_len !== 10'd0 || o_kc_ibytes_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid gnt %b rdy %b mode %0d il %0d ol %0d v %b want all 0",
               o_req_gnt, o_req_ibytes_ready, o_kc_mode, o_kc_ibytes_len,
               o_kc_obytes_len, o_kc_ibytes_valid);
    end
    i_kc_ibytes_ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    xact(2'b11, 8, 8, 2'd0, 0, 0, 0, 0, g, lat, beats, bad, orr, dv, pulses, m, il, ol, ga);
    i_req = '0;
    checks++;
    if (g !== 2'b01 || lat != 1) begin
      errors++;
      $display("FAIL rst_ptr gnt %b lat %0d want 01 lat 1", g, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fairness();
    test_single();
    test_lengths();
    test_config_stable();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
